// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour width and the per-axis state encoding.
package vga_pkg;

  localparam int unsigned CW        = 12;
  localparam int unsigned H_SYNC_D  = 96;
  localparam int unsigned H_BP_D    = 48;
  localparam int unsigned H_ACT_D   = 640;
  localparam int unsigned H_TOTAL_D = 800;
  localparam int unsigned V_SYNC_D  = 2;
  localparam int unsigned V_BP_D    = 33;
  localparam int unsigned V_ACT_D   = 480;
  localparam int unsigned V_TOTAL_D = 525;

  typedef enum logic [1:0] {
    AX_SYNC,
    AX_BACK,
    AX_ACTIVE,
    AX_FRONT
  } axis_state_e;

  // Region of one axis for a given counter value; the sync pulse starts at 0.
  function automatic axis_state_e axis_decode(input logic [15:0] c,
                                              input logic [15:0] s,
                                              input logic [15:0] b,
                                              input logic [15:0] a);
    if (c < s)                 return AX_SYNC;
    else if (c < s + b)        return AX_BACK;
    else if (c < s + b + a)    return AX_ACTIVE;
    else                       return AX_FRONT;
  endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// One timing axis: wrapping position counter plus a registered region FSM.
module vga_axis_ctr
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [15:0] sync_w_i,
  input  logic [15:0] bp_w_i,
  input  logic [15:0] act_w_i,
  input  logic [15:0] total_i,
  output logic [15:0] count_o,
  output axis_state_e state_o,
  output logic        sync_n_o,
  output logic        active_o,
  output logic        wrap_o
);

  logic [15:0] count_q, count_d;
  axis_state_e state_q, state_d;

  assign wrap_o = en_i && (count_q == total_i - 16'd1);

  // Next count and region; both only move on the enable strobe.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + 16'd1;
      state_d = axis_decode(count_d, sync_w_i, bp_w_i, act_w_i);
    end
  end

  // Counter and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      state_q <= AX_SYNC;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign count_o  = count_q;
  assign state_o  = state_q;
  assign sync_n_o = (state_q != AX_SYNC);
  assign active_o = (state_q == AX_ACTIVE);

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: pixel divider, H/V axis counters, sync/visible delay
// line and colour blanking. DIV must be at least 2.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned DIV     = 4,
  parameter int unsigned H_SYNC  = H_SYNC_D,
  parameter int unsigned H_BP    = H_BP_D,
  parameter int unsigned H_ACT   = H_ACT_D,
  parameter int unsigned H_TOTAL = H_TOTAL_D,
  parameter int unsigned V_SYNC  = V_SYNC_D,
  parameter int unsigned V_BP    = V_BP_D,
  parameter int unsigned V_ACT   = V_ACT_D,
  parameter int unsigned V_TOTAL = V_TOTAL_D,
  parameter int unsigned LAT     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] rgb_in,
  output logic [15:0]   posx,
  output logic [15:0]   posy,
  output logic          pix_tick,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] rgb_out
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          frame_start_q;
  logic          h_wrap, v_wrap, h_sync_n, v_sync_n, h_active, v_active;
  logic          vis_raw, vis_tap;
  axis_state_e   h_state, v_state;
  logic          unused_state;
  logic [LAT:0]  hs_q, vs_q;
  logic [CW-1:0] rgb_q;

  assign pix_tick = (div_q == DW'(DIV - 1));

  // Divider next value: count up to DIV-1, then wrap.
  always_comb begin
    div_d = div_q + DW'(1);
    if (pix_tick) div_d = '0;
  end

  // Divider and undelayed frame-start strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      frame_start_q <= v_wrap;
    end
  end

  vga_axis_ctr u_h (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (pix_tick),
    .sync_w_i (16'(H_SYNC)),
    .bp_w_i   (16'(H_BP)),
    .act_w_i  (16'(H_ACT)),
    .total_i  (16'(H_TOTAL)),
    .count_o  (posx),
    .state_o  (h_state),
    .sync_n_o (h_sync_n),
    .active_o (h_active),
    .wrap_o   (h_wrap)
  );

  // Vertical axis advances once per line wrap; its wrap is the frame wrap.
  vga_axis_ctr u_v (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (h_wrap),
    .sync_w_i (16'(V_SYNC)),
    .bp_w_i   (16'(V_BP)),
    .act_w_i  (16'(V_ACT)),
    .total_i  (16'(V_TOTAL)),
    .count_o  (posy),
    .state_o  (v_state),
    .sync_n_o (v_sync_n),
    .active_o (v_active),
    .wrap_o   (v_wrap)
  );

  // Region states are exposed for debug taps only.
  assign unused_state = ^{h_state, v_state};

  assign vis_raw = h_active & v_active;

  // The colour register is itself the last visible stage, so the visible
  // tap sits one stage earlier than the sync taps to keep them aligned.
  if (LAT == 0) begin : g_vis0
    assign vis_tap = vis_raw;
  end else begin : g_visn
    logic [LAT-1:0] vis_q;
    // Visible-flag shift register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vis_q <= '0;
      end else begin
        vis_q[0] <= vis_raw;
        for (int unsigned i = 1; i < LAT; i++) vis_q[i] <= vis_q[i-1];
      end
    end
    assign vis_tap = vis_q[LAT-1];
  end

  // Sync shift registers and blanked colour output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= '1;
      vs_q  <= '1;
      rgb_q <= '0;
    end else begin
      hs_q[0] <= h_sync_n;
      vs_q[0] <= v_sync_n;
      for (int unsigned i = 1; i <= LAT; i++) begin
        hs_q[i] <= hs_q[i-1];
        vs_q[i] <= vs_q[i-1];
      end
      rgb_q <= vis_tap ? rgb_in : '0;
    end
  end

  assign frame_start = frame_start_q;
  assign hsync       = hs_q[LAT];
  assign vsync       = vs_q[LAT];
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a small-timing instance (DIV=2, 16x8 total) at LAT
// 2, 0 and 7, plus a default-parameter instance for the 800-pixel line.
module tb_vga_timing;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] rgb_in = 12'hABC;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned edges = 0;

  always #5 clk = ~clk;

  logic [15:0] m_x, m_y, z_x, z_y, s_x, s_y, d_x, d_y;
  logic        m_pt, m_fs, m_hs, m_vs, z_pt, z_fs, z_hs, z_vs;
  logic        s_pt, s_fs, s_hs, s_vs, d_pt, d_fs, d_hs, d_vs;
  logic [11:0] m_rgb, z_rgb, s_rgb, d_rgb;

  vga_timing #(.DIV(2), .H_SYNC(4), .H_BP(2), .H_ACT(8), .H_TOTAL(16),
               .V_SYNC(2), .V_BP(1), .V_ACT(3), .V_TOTAL(8), .LAT(2)) u_m (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .posx(m_x), .posy(m_y),
    .pix_tick(m_pt), .frame_start(m_fs), .hsync(m_hs), .vsync(m_vs), .rgb_out(m_rgb));

  vga_timing #(.DIV(2), .H_SYNC(4), .H_BP(2), .H_ACT(8), .H_TOTAL(16),
               .V_SYNC(2), .V_BP(1), .V_ACT(3), .V_TOTAL(8), .LAT(0)) u_z (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .posx(z_x), .posy(z_y),
    .pix_tick(z_pt), .frame_start(z_fs), .hsync(z_hs), .vsync(z_vs), .rgb_out(z_rgb));

  vga_timing #(.DIV(2), .H_SYNC(4), .H_BP(2), .H_ACT(8), .H_TOTAL(16),
               .V_SYNC(2), .V_BP(1), .V_ACT(3), .V_TOTAL(8), .LAT(7)) u_s (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .posx(s_x), .posy(s_y),
    .pix_tick(s_pt), .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs), .rgb_out(s_rgb));

  vga_timing u_d (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .posx(d_x), .posy(d_y),
    .pix_tick(d_pt), .frame_start(d_fs), .hsync(d_hs), .vsync(d_vs), .rgb_out(d_rgb));

  typedef struct {
    int unsigned n;
    logic [15:0] x, y;
    logic        pt, fs, hs, vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Advance to the sample point just after rising edge number n.
  task automatic adv_to(input int unsigned n);
    while (edges < n) begin
      @(posedge clk);
      edges++;
    end
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    edges++;
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned hs_lo, vs_lo, nz, bad, fs_m, fs_z, fs_s, fs_k_m, fs_k_z, fs_k_s;
    int unsigned hf_m, hf_z, hf_s, rf_m, rf_z, rf_s, cnt, tk, tgt;
    bit found;

    //             n    x   y  pt fs hs vs rgb
    tbl[0]  = '{  0,  0,  0, 0, 0, 1, 1, 12'h000};
    tbl[1]  = '{  1,  0,  0, 1, 0, 1, 1, 12'h000};
    tbl[2]  = '{  2,  1,  0, 0, 0, 1, 1, 12'h000};
    tbl[3]  = '{  3,  1,  0, 1, 0, 0, 0, 12'h000};
    tbl[4]  = '{  8,  4,  0, 0, 0, 0, 0, 12'h000};
    tbl[5]  = '{ 11,  5,  0, 1, 0, 1, 0, 12'h000};
    tbl[6]  = '{ 32,  0,  1, 0, 0, 1, 0, 12'h000};
    tbl[7]  = '{ 83,  9,  2, 1, 0, 1, 1, 12'h000};
    tbl[8]  = '{110,  7,  3, 0, 0, 1, 1, 12'h000};
    tbl[9]  = '{111,  7,  3, 1, 0, 1, 1, 12'hABC};
    tbl[10] = '{126, 15,  3, 0, 0, 1, 1, 12'hABC};
    tbl[11] = '{127, 15,  3, 1, 0, 1, 1, 12'h000};
    tbl[12] = '{175,  7,  5, 1, 0, 1, 1, 12'hABC};
    tbl[13] = '{207,  7,  6, 1, 0, 1, 1, 12'h000};
    tbl[14] = '{255, 15,  7, 1, 0, 1, 1, 12'h000};
    tbl[15] = '{256,  0,  0, 0, 1, 1, 1, 12'h000};
    tbl[16] = '{257,  0,  0, 1, 0, 1, 1, 12'h000};
    tbl[17] = '{259,  1,  0, 1, 0, 0, 0, 12'h000};

    // Values held during reset.
    repeat (3) @(posedge clk);
    #2;
    chk("rst.posx", 32'(m_x), 0);
    chk("rst.posy", 32'(m_y), 0);
    chk("rst.tick", 32'(m_pt), 0);
    chk("rst.hsync", 32'(m_hs), 1);
    chk("rst.vsync", 32'(m_vs), 1);
    chk("rst.rgb", 32'(m_rgb), 0);
    chk("rst.fs", 32'(m_fs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;

    for (int i = 0; i < 18; i++) begin
      adv_to(tbl[i].n);
      chk($sformatf("v%0d.posx", i), 32'(m_x), 32'(tbl[i].x));
      chk($sformatf("v%0d.posy", i), 32'(m_y), 32'(tbl[i].y));
      chk($sformatf("v%0d.tick", i), 32'(m_pt), 32'(tbl[i].pt));
      chk($sformatf("v%0d.fs", i), 32'(m_fs), 32'(tbl[i].fs));
      chk($sformatf("v%0d.hsync", i), 32'(m_hs), 32'(tbl[i].hs));
      chk($sformatf("v%0d.vsync", i), 32'(m_vs), 32'(tbl[i].vs));
      chk($sformatf("v%0d.rgb", i), 32'(m_rgb), 32'(tbl[i].rgb));
    end

    // One full frame from a frame_start, on all three latencies.
    found = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      step();
      if (m_fs) found = 1;
    end
    chk("frame.fs_found", 32'(found), 1);
    hs_lo = 0; vs_lo = 0; nz = 0; bad = 0;
    fs_m = 0; fs_z = 0; fs_s = 0; fs_k_m = 0; fs_k_z = 0; fs_k_s = 0;
    hf_m = 0; hf_z = 0; hf_s = 0; rf_m = 0; rf_z = 0; rf_s = 0;
    for (int unsigned k = 1; k <= 256; k++) begin
      step();
      if (!m_hs) hs_lo++;
      if (!m_vs) vs_lo++;
      if (m_rgb != 0) nz++;
      if (m_rgb != 0 && m_rgb != 12'hABC) bad++;
      if (m_fs) begin fs_m++; fs_k_m = k; end
      if (z_fs) begin fs_z++; fs_k_z = k; end
      if (s_fs) begin fs_s++; fs_k_s = k; end
      if (!m_hs && hf_m == 0) hf_m = k;
      if (!z_hs && hf_z == 0) hf_z = k;
      if (!s_hs && hf_s == 0) hf_s = k;
      if (m_rgb != 0 && rf_m == 0) rf_m = k;
      if (z_rgb != 0 && rf_z == 0) rf_z = k;
      if (s_rgb != 0 && rf_s == 0) rf_s = k;
    end
    chk("frame.fs_count", fs_m, 1);
    chk("frame.period", fs_k_m, 256);
    chk("lat0.fs_count", fs_z, 1);
    chk("lat0.period", fs_k_z, 256);
    chk("lat7.fs_count", fs_s, 1);
    chk("lat7.period", fs_k_s, 256);
    chk("frame.hsync_low", hs_lo, 64);
    chk("frame.vsync_low", vs_lo, 64);
    chk("frame.rgb_nonzero", nz, 48);
    chk("frame.rgb_wrong", bad, 0);
    chk("lat2.hsync_delay", hf_m, 3);
    chk("lat0.hsync_delay", hf_z, 1);
    chk("lat7.hsync_delay", hf_s, 8);
    chk("lat2.rgb_delay", rf_m, 111);
    chk("lat0.rgb_delay", rf_z, 109);
    chk("lat7.rgb_delay", rf_s, 116);

    // Default timing: first line wrap and one line of hsync.
    adv_to(3199);
    chk("def.posx_799", 32'(d_x), 799);
    chk("def.posy_0", 32'(d_y), 0);
    adv_to(3200);
    chk("def.posx_wrap", 32'(d_x), 0);
    chk("def.posy_1", 32'(d_y), 1);
    hs_lo = 0; cnt = 0;
    for (int k = 0; k < 3200; k++) begin
      step();
      if (!d_hs) hs_lo++;
      if (d_pt) cnt++;
    end
    chk("def.hsync_low", hs_lo, 384);
    chk("def.ticks_line", cnt, 800);

    // Reset mid-frame while the delayed view is visible.
    tgt = (edges / 256 + 1) * 256 + 150;
    adv_to(tgt);
    chk("mid.pre_posx", 32'(m_x), 11);
    chk("mid.pre_rgb", 32'(m_rgb), 32'h0ABC);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.posx", 32'(m_x), 0);
    chk("mid.posy", 32'(m_y), 0);
    chk("mid.rgb", 32'(m_rgb), 0);
    chk("mid.hsync", 32'(m_hs), 1);
    chk("mid.vsync", 32'(m_vs), 1);
    chk("mid.def_posx", 32'(d_x), 0);
    chk("mid.def_posy", 32'(d_y), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    adv_to(3);
    chk("rel.def_tick3", 32'(d_pt), 1);
    chk("rel.def_posx3", 32'(d_x), 0);
    chk("rel.posx3", 32'(m_x), 1);
    chk("rel.fs3", 32'(m_fs), 0);
    adv_to(4);
    chk("rel.def_posx4", 32'(d_x), 1);
    chk("rel.def_tick4", 32'(d_pt), 0);
    cnt = 0; tk = 0;
    while (edges < 300) begin
      step();
      if (m_fs) begin cnt++; tk = edges; end
    end
    chk("rel.fs_count", cnt, 1);
    chk("rel.fs_edge", tk, 256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter DIV, default 4: clk cycles per pixel tick (100 MHz clk gives a 25 MHz pixel rate).
REQ-002 Parameter H_SYNC/H_BP/H_ACT/H_TOTAL, defaults 96/48/640/800: horizontal timing in pixels.
REQ-003 Parameter V_SYNC/V_BP/V_ACT/V_TOTAL, defaults 2/33/480/525: vertical timing in lines.
REQ-004 Parameter LAT, default 2: renderer latency in clk cycles, range 0..7.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 rgb_in  input  12  pixel colour from the renderer, valid LAT clk cycles after posx/posy change.
REQ-008 posx  output  16  horizontal counter, 0..H_TOTAL-1; sync pulse starts at 0.
REQ-009 posy  output  16  vertical counter, 0..V_TOTAL-1; sync pulse starts at 0.
REQ-010 pix_tick  output  1  one-clk strobe; posx/posy advance on the clk after the strobe.
REQ-011 frame_start  output  1  one-clk pulse when posx=0 and posy=0 are entered.
REQ-012 hsync, vsync  output  1 each  active-low sync, delayed by LAT cycles.
REQ-013 rgb_out  output  12  colour to the DAC pins, delayed by LAT cycles and blanked outside the active area.

Function
REQ-014 Divider counts 0..DIV-1 and wraps; pix_tick=1 exactly when the divider equals DIV-1.
REQ-015 On pix_tick: posx increments; at H_TOTAL-1 it wraps to 0 and posy increments.
REQ-016 posy wraps from V_TOTAL-1 to 0 on the same tick in which posx wraps.
REQ-017 Horizontal FSM states SYNC, BACK, ACTIVE, FRONT are decoded from posx.
  - Boundaries at H_SYNC, H_SYNC+H_BP and H_SYNC+H_BP+H_ACT (defaults 96, 144, 784).
  - Transitions occur only on pix_tick.
REQ-018 Vertical FSM states SYNC, BACK, ACTIVE, FRONT are decoded from posy.
  - Boundaries at 2, 35 and 515 (defaults).
  - Transitions occur only on the line wrap.
REQ-019 Active area is posx 144..783 and posy 35..514; the raw hsync/vsync terms are low in the SYNC states.
REQ-020 A raw visible flag is 1 when both FSMs are in ACTIVE.
REQ-021 Visible, hsync and vsync pass through a LAT-deep shift register clocked every clk.
  - LAT=0 means registered-only (1 cycle).
  - LAT=N gives N+1 cycles total.
REQ-022 rgb_out is registered each clk: delayed-visible ? rgb_in : 12'h000.
REQ-023 frame_start asserts for exactly one clk per frame.
  - It is undelayed: aligned with posx/posy, not with the sync outputs.
REQ-024 All counter arithmetic is unsigned; posx/posy upper bits stay 0 (no overflow past TOTAL-1).

Reset
REQ-025 While rst_n=0, the block holds these values asynchronously:
  - divider=0, posx=0, posy=0, pix_tick=0, frame_start=0.
  - hsync=1, vsync=1, rgb_out=0, every shift-register stage inactive.
REQ-026 After rst_n rises, the first pix_tick occurs on the DIV-th clk edge.
  - frame_start pulses one clk after that first tick's counter update, for the next frame only (no pulse out of reset).
REQ-027 Reset asserted mid-line or mid-frame aborts immediately.
  - The block restarts from posx=0, posy=0 with no partial-frame continuation.

Structure
REQ-028 Timing defaults (the 800/525 totals, sync/porch widths, 12-bit colour width) and the H/V state enumeration live in a shared package, vga_pkg.
REQ-029 One sub-module, vga_axis_ctr, is instantiated twice (horizontal, vertical).
  - Inputs: enable strobe and the four widths.
  - Outputs: count, state, raw sync, active, wrap.
REQ-030 The delay line and colour blanking stay in vga_timing.

Verification
REQ-031 Reset release, DIV=4: pix_tick on clk 4, 8, 12…; posx reaches 1 after clk 4.
  - posx=799→0 and posy 0→1 after 3200 clk.
REQ-032 Full frame: exactly 800×525×4 = 1,680,000 clk between frame_start pulses.
  - hsync low for 96×4 = 384 clk per line.
  - vsync low for 2 lines = 6400 clk.
REQ-033 rgb_in held at 12'hABC, LAT=2:
  - rgb_out=12'hABC only during posx 144..783 and posy 35..514, shifted 3 clk late.
  - rgb_out=0 elsewhere.
  - Count 640×480×4 non-zero clk per frame.
REQ-034 Boundaries, LAT=2 delayed view: posx=143→0, 144→visible, 783→visible, 784→0.
  - posy=34 gives a black line; posy=514 is the last visible line.
REQ-035 Assert rst_n=0 at posx=400, posy=300:
  - Outputs reset within the same clk (async).
  - After release the next frame_start comes after a full frame of 1,680,000 clk.
REQ-036 Sweep LAT=0 and 7: sync-to-rgb alignment delay is 1 and 8 clk respectively, with the frame period unchanged.
